// File: rtl/adma_mem_pkg.sv
// Shared types and response codes for the adma AXI memory slave.
package adma_mem_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/adma_mem_array.sv
// 1-write/1-read word array: synchronous write, asynchronous read.
// A read of the word being written in the same cycle sees the old contents.
module adma_mem_array #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 256,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/adma_axi_mem_slv.sv
// AXI4 slave memory responder: INCR bursts, one outstanding transaction per
// direction, independent read and write paths.
module adma_axi_mem_slv
  import adma_mem_pkg::*;
#(
  parameter              MEM_BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH        = 1024,
  parameter int unsigned DATA_W           = 256,
  parameter int unsigned ADDR_W           = 32,
  parameter int unsigned MST_ID_W         = 5,
  parameter int unsigned TRANS_DATA_LEN_W = 8,
  parameter int unsigned TRANS_RESP_W     = 2
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [MST_ID_W-1:0]         s_awid_i,
  input  logic [ADDR_W-1:0]           s_awaddr_i,
  input  logic [TRANS_DATA_LEN_W-1:0] s_awlen_i,
  input  logic                        s_awvalid_i,
  output logic                        s_awready_o,
  input  logic [DATA_W-1:0]           s_wdata_i,
  input  logic                        s_wlast_i,
  input  logic                        s_wvalid_i,
  output logic                        s_wready_o,
  output logic [MST_ID_W-1:0]         s_bid_o,
  output logic [TRANS_RESP_W-1:0]     s_bresp_o,
  output logic                        s_bvalid_o,
  input  logic                        s_bready_i,
  input  logic [MST_ID_W-1:0]         s_arid_i,
  input  logic [ADDR_W-1:0]           s_araddr_i,
  input  logic [TRANS_DATA_LEN_W-1:0] s_arlen_i,
  input  logic                        s_arvalid_i,
  output logic                        s_arready_o,
  output logic [MST_ID_W-1:0]         s_rid_o,
  output logic [DATA_W-1:0]           s_rdata_o,
  output logic [TRANS_RESP_W-1:0]     s_rresp_o,
  output logic                        s_rlast_o,
  output logic                        s_rvalid_o,
  input  logic                        s_rready_i
);

  localparam int unsigned     SHIFT   = $clog2(DATA_W / 8);
  localparam int unsigned     IDX_W   = $clog2(MEM_DEPTH);
  localparam int unsigned     CNT_W   = TRANS_DATA_LEN_W + 1;
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(MEM_BASE_ADDR);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

  function automatic logic [ADDR_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return (a - BASE) >> SHIFT;
  endfunction

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr, mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  adma_mem_array #(
    .DEPTH  (MEM_DEPTH),
    .DATA_W (DATA_W),
    .AW     (IDX_W)
  ) u_mem (
    .clk   (aclk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (s_wdata_i),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // ---------------- write path ----------------
  wr_state_t                   w_state, w_next;
  logic [MST_ID_W-1:0]         w_id;
  logic [ADDR_W-1:0]           w_idx;
  logic                        w_below;
  logic [TRANS_DATA_LEN_W-1:0] w_len;
  logic [CNT_W-1:0]            w_cnt;
  logic                        w_dec_err, w_prot_err;
  logic                        aw_hs, w_hs, w_in_range;

  assign aw_hs      = s_awvalid_i && (w_state == W_IDLE);
  assign w_hs       = s_wvalid_i && (w_state == W_DATA);
  // The below-base flag is latched per burst since the index alone wraps.
  assign w_in_range = !w_below && (w_idx < DEPTH_A);
  assign mem_we     = w_hs && w_in_range;
  assign mem_waddr  = w_idx[IDX_W-1:0];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && s_wlast_i) w_next = W_RESP;
      W_RESP:  if (s_bready_i) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    s_awready_o = (w_state == W_IDLE);
    s_wready_o  = (w_state == W_DATA);
    s_bvalid_o  = (w_state == W_RESP);
    s_bid_o     = w_id;
    if (w_dec_err)       s_bresp_o = TRANS_RESP_W'(RESP_DECERR);
    else if (w_prot_err) s_bresp_o = TRANS_RESP_W'(RESP_SLVERR);
    else                 s_bresp_o = TRANS_RESP_W'(RESP_OKAY);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_id       <= '0;
      w_idx      <= '0;
      w_below    <= 1'b0;
      w_len      <= '0;
      w_cnt      <= '0;
      w_dec_err  <= 1'b0;
      w_prot_err <= 1'b0;
    end else if (aw_hs) begin
      w_id       <= s_awid_i;
      w_idx      <= word_idx(s_awaddr_i);
      w_below    <= (s_awaddr_i < BASE);
      w_len      <= s_awlen_i;
      w_cnt      <= '0;
      w_dec_err  <= 1'b0;
      w_prot_err <= 1'b0;
    end else if (w_hs) begin
      if (!w_in_range) w_dec_err <= 1'b1;
      if (s_wlast_i != (w_cnt == {1'b0, w_len})) w_prot_err <= 1'b1;
      w_idx <= w_idx + 1'b1;
      w_cnt <= w_cnt + 1'b1;
    end
  end

  // ---------------- read path ----------------
  rd_state_t                   r_state, r_next;
  logic [MST_ID_W-1:0]         r_id;
  logic [TRANS_DATA_LEN_W-1:0] r_len, r_cnt;
  logic [ADDR_W-1:0]           r_idx, lk_idx;
  logic                        r_below, lk_below, lk_ok;
  logic [DATA_W-1:0]           r_data;
  logic [TRANS_RESP_W-1:0]     r_resp;
  logic                        ar_hs, r_hs, r_last;

  assign ar_hs  = s_arvalid_i && (r_state == R_IDLE);
  assign r_hs   = s_rready_i && (r_state == R_DATA);
  assign r_last = (r_cnt == r_len);

  // Look-up address: beat 0 of a new burst when idle, else the next beat.
  assign lk_idx    = (r_state == R_IDLE) ? word_idx(s_araddr_i) : r_idx + 1'b1;
  assign lk_below  = (r_state == R_IDLE) ? (s_araddr_i < BASE) : r_below;
  assign lk_ok     = !lk_below && (lk_idx < DEPTH_A);
  assign mem_raddr = lk_idx[IDX_W-1:0];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && r_last) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    s_arready_o = (r_state == R_IDLE);
    s_rvalid_o  = (r_state == R_DATA);
    s_rlast_o   = (r_state == R_DATA) && r_last;
    s_rid_o     = r_id;
    s_rdata_o   = r_data;
    s_rresp_o   = r_resp;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_id    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_below <= 1'b0;
      r_data  <= '0;
      r_resp  <= '0;
    end else if (ar_hs || (r_hs && !r_last)) begin
      if (ar_hs) begin
        r_id  <= s_arid_i;
        r_len <= s_arlen_i;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_idx   <= lk_idx;
      r_below <= lk_below;
      r_data  <= lk_ok ? mem_rdata : '0;
      r_resp  <= lk_ok ? TRANS_RESP_W'(RESP_OKAY) : TRANS_RESP_W'(RESP_DECERR);
    end
  end

endmodule

// File: tb/tb_adma_axi_mem_slv.sv
// Randomized and directed bench for adma_axi_mem_slv against a word-level
// memory model with expected-beat queues.
module tb_adma_axi_mem_slv;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [4:0]  s_awid_i = '0, s_arid_i = '0;
  logic [31:0] s_awaddr_i = '0, s_araddr_i = '0;
  logic [7:0]  s_awlen_i = '0, s_arlen_i = '0;
  logic        s_awvalid_i = 1'b0, s_arvalid_i = 1'b0;
  logic [31:0] s_wdata_i = '0;
  logic        s_wlast_i = 1'b0, s_wvalid_i = 1'b0;
  logic        s_bready_i = 1'b0, s_rready_i = 1'b0;
  logic        s_awready_o, s_wready_o, s_bvalid_o, s_arready_o, s_rlast_o, s_rvalid_o;
  logic [4:0]  s_bid_o, s_rid_o;
  logic [1:0]  s_bresp_o, s_rresp_o;
  logic [31:0] s_rdata_o;

  adma_axi_mem_slv #(
    .MEM_BASE_ADDR (BASE),
    .MEM_DEPTH     (DEPTH),
    .DATA_W        (32),
    .ADDR_W        (32),
    .MST_ID_W      (5),
    .TRANS_DATA_LEN_W (8),
    .TRANS_RESP_W  (2)
  ) dut (
    .aclk (aclk), .aresetn (aresetn),
    .s_awid_i (s_awid_i), .s_awaddr_i (s_awaddr_i), .s_awlen_i (s_awlen_i),
    .s_awvalid_i (s_awvalid_i), .s_awready_o (s_awready_o),
    .s_wdata_i (s_wdata_i), .s_wlast_i (s_wlast_i), .s_wvalid_i (s_wvalid_i),
    .s_wready_o (s_wready_o),
    .s_bid_o (s_bid_o), .s_bresp_o (s_bresp_o), .s_bvalid_o (s_bvalid_o),
    .s_bready_i (s_bready_i),
    .s_arid_i (s_arid_i), .s_araddr_i (s_araddr_i), .s_arlen_i (s_arlen_i),
    .s_arvalid_i (s_arvalid_i), .s_arready_o (s_arready_o),
    .s_rid_o (s_rid_o), .s_rdata_o (s_rdata_o), .s_rresp_o (s_rresp_o),
    .s_rlast_o (s_rlast_o), .s_rvalid_o (s_rvalid_o), .s_rready_i (s_rready_i)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    bit          known;
  } rbeat_t;

  logic [31:0] ref_mem [DEPTH];
  bit          ref_known [DEPTH];
  rbeat_t      rq [$];
  int          wph = 0;       // 0 idle, 1 data, 2 response
  bit          busy = 1'b0;
  logic [4:0]  m_wid, m_rid;
  logic [31:0] m_waddr;
  int          m_wlen, m_n;
  bit          m_oor;
  logic [1:0]  exp_bresp;

  logic [1:0]  last_bresp;
  logic [4:0]  last_bid;
  logic [31:0] log_data [$];
  logic [1:0]  log_resp [$];
  logic        log_last [$];

  function automatic bit in_win(input logic [31:0] a, input int i, output int idx);
    idx = 0;
    if (a < BASE) return 1'b0;
    idx = int'((a - BASE) >> 2) + i;
    return idx < DEPTH;
  endfunction

  initial for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;

  always @(negedge aclk) begin
    if (!aresetn) begin
      chk("rst_awready", 64'(s_awready_o), 64'd1);
      chk("rst_arready", 64'(s_arready_o), 64'd1);
      chk("rst_wready",  64'(s_wready_o),  64'd0);
      chk("rst_bvalid",  64'(s_bvalid_o),  64'd0);
      chk("rst_rvalid",  64'(s_rvalid_o),  64'd0);
      chk("rst_rlast",   64'(s_rlast_o),   64'd0);
      chk("rst_bid",     64'(s_bid_o),     64'd0);
      chk("rst_rid",     64'(s_rid_o),     64'd0);
      chk("rst_bresp",   64'(s_bresp_o),   64'd0);
      chk("rst_rresp",   64'(s_rresp_o),   64'd0);
      chk("rst_rdata",   64'(s_rdata_o),   64'd0);
      wph  = 0;
      busy = 1'b0;
      rq.delete();
    end else begin
      chk("awready", 64'(s_awready_o), 64'(wph == 0));
      chk("wready",  64'(s_wready_o),  64'(wph == 1));
      chk("bvalid",  64'(s_bvalid_o),  64'(wph == 2));
      chk("arready", 64'(s_arready_o), 64'(!busy));
      chk("rvalid",  64'(s_rvalid_o),  64'(busy));

      if (s_bvalid_o) begin
        chk("bresp", 64'(s_bresp_o), 64'(exp_bresp));
        chk("bid",   64'(s_bid_o),   64'(m_wid));
        if (s_bready_i) begin
          last_bresp = s_bresp_o;
          last_bid   = s_bid_o;
          wph        = 0;
        end
      end

      if (s_rvalid_o) begin
        if (rq.size() == 0) begin
          chk("r_unexpected", 64'd1, 64'd0);
        end else begin
          rbeat_t b;
          b = rq[0];
          if (b.known) chk("rdata", 64'(s_rdata_o), 64'(b.data));
          chk("rresp", 64'(s_rresp_o), 64'(b.resp));
          chk("rlast", 64'(s_rlast_o), 64'(b.last));
          chk("rid",   64'(s_rid_o),   64'(m_rid));
          if (s_rready_i) begin
            log_data.push_back(s_rdata_o);
            log_resp.push_back(s_rresp_o);
            log_last.push_back(s_rlast_o);
            void'(rq.pop_front());
            if (b.last) busy = 1'b0;
          end
        end
      end

      // Read expectations are taken before this cycle's write lands.
      if (s_arvalid_i && s_arready_o) begin
        busy  = 1'b1;
        m_rid = s_arid_i;
        for (int i = 0; i <= int'(s_arlen_i); i++) begin
          rbeat_t b;
          int     idx;
          bit     ok;
          ok      = in_win(s_araddr_i, i, idx);
          b.data  = ok ? ref_mem[idx] : 32'h0;
          b.known = ok ? ref_known[idx] : 1'b1;
          b.resp  = ok ? 2'b00 : 2'b11;
          b.last  = (i == int'(s_arlen_i));
          rq.push_back(b);
        end
      end

      if (s_wvalid_i && s_wready_o) begin
        int idx;
        if (in_win(m_waddr, m_n, idx)) begin
          ref_mem[idx]   = s_wdata_i;
          ref_known[idx] = 1'b1;
        end else begin
          m_oor = 1'b1;
        end
        m_n++;
        if (s_wlast_i) begin
          exp_bresp = m_oor ? 2'b11 : ((m_n != m_wlen + 1) ? 2'b10 : 2'b00);
          wph = 2;
        end
      end

      if (s_awvalid_i && s_awready_o) begin
        wph     = 1;
        m_wid   = s_awid_i;
        m_waddr = s_awaddr_i;
        m_wlen  = int'(s_awlen_i);
        m_n     = 0;
        m_oor   = 1'b0;
      end
    end
  end

  // ---------------- drivers ----------------
  function automatic bit sig_sel(input int s);
    case (s)
      0: return s_awready_o;
      1: return s_wready_o;
      2: return s_bvalid_o;
      default: return s_arready_o;
    endcase
  endfunction

  task automatic wait_for(input int s, input string nm);
    int t = 0;
    while (!sig_sel(s) && t < 200) begin
      @(posedge aclk); #1;
      t++;
    end
    chk(nm, 64'(t < 200), 64'd1);
  endtask

  task automatic do_write(input logic [4:0] id, input logic [31:0] addr, input int len,
                          input int nbeats, input logic [31:0] d0, input bit rnd);
    @(posedge aclk); #1;
    s_awid_i = id; s_awaddr_i = addr; s_awlen_i = len[7:0]; s_awvalid_i = 1'b1;
    wait_for(0, "timeout_aw");
    @(posedge aclk); #1;
    s_awvalid_i = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        s_wvalid_i = 1'b0;
        @(posedge aclk); #1;
      end
      s_wvalid_i = 1'b1;
      s_wdata_i  = rnd ? $urandom : d0 + 32'(i);
      s_wlast_i  = (i == nbeats - 1);
      wait_for(1, "timeout_w");
      @(posedge aclk); #1;
      s_wvalid_i = 1'b0;
      s_wlast_i  = 1'b0;
    end
    if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
    s_bready_i = 1'b1;
    wait_for(2, "timeout_b");
    @(posedge aclk); #1;
    s_bready_i = 1'b0;
  endtask

  // mode: 0 rready held high, 1 toggling, 2 random
  task automatic do_read(input logic [4:0] id, input logic [31:0] addr, input int len,
                         input int mode, output int cyc);
    bit done = 1'b0;
    cyc = 0;
    @(posedge aclk); #1;
    s_arid_i = id; s_araddr_i = addr; s_arlen_i = len[7:0]; s_arvalid_i = 1'b1;
    wait_for(3, "timeout_ar");
    @(posedge aclk); #1;
    s_arvalid_i = 1'b0;
    s_rready_i  = 1'b0;
    while (!done && cyc < 2000) begin
      if (mode == 0)      s_rready_i = 1'b1;
      else if (mode == 1) s_rready_i = ~s_rready_i;
      else                s_rready_i = 1'($urandom_range(0, 1));
      if (s_rvalid_o && s_rready_i && s_rlast_o) done = 1'b1;
      @(posedge aclk); #1;
      cyc++;
    end
    s_rready_i = 1'b0;
    chk("timeout_r", 64'(done), 64'd1);
  endtask

  task automatic clr_log();
    log_data.delete(); log_resp.delete(); log_last.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;

    // 4-beat write then read at the window base
    do_write(5'd5, BASE, 3, 4, 32'hA0, 1'b0);
    chk("t1_bresp", 64'(last_bresp), 64'h0);
    chk("t1_bid",   64'(last_bid),   64'd5);
    clr_log();
    do_read(5'd6, BASE, 3, 0, cyc);
    chk("t1_cycles", 64'(cyc), 64'd4);
    for (int i = 0; i < 4; i++) chk("t1_rdata", 64'(log_data[i]), 64'(32'hA0 + 32'(i)));
    chk("t1_rlast3", 64'(log_last[3]), 64'd1);
    chk("t1_rlast2", 64'(log_last[2]), 64'd0);

    // burst running off the top of the window
    do_write(5'd7, BASE + 32'(4 * (DEPTH - 2)), 3, 4, 32'hD0, 1'b0);
    chk("t2_bresp", 64'(last_bresp), 64'h3);
    clr_log();
    do_read(5'd8, BASE + 32'(4 * (DEPTH - 2)), 3, 0, cyc);
    chk("t2_resp0", 64'(log_resp[0]), 64'h0);
    chk("t2_resp1", 64'(log_resp[1]), 64'h0);
    chk("t2_resp2", 64'(log_resp[2]), 64'h3);
    chk("t2_resp3", 64'(log_resp[3]), 64'h3);
    chk("t2_data1", 64'(log_data[1]), 64'hD1);
    chk("t2_data2", 64'(log_data[2]), 64'h0);
    chk("t2_data3", 64'(log_data[3]), 64'h0);

    // early and late wlast
    do_write(5'd9, BASE + 32'd32, 3, 2, 32'hE0, 1'b0);
    chk("t3_bresp", 64'(last_bresp), 64'h2);
    do_write(5'd10, BASE + 32'd40, 1, 4, 32'hF0, 1'b0);
    chk("t4_bresp", 64'(last_bresp), 64'h2);

    // 8-beat read with rready toggling
    do_write(5'd11, BASE, 7, 8, 32'hB0, 1'b0);
    clr_log();
    do_read(5'd12, BASE, 7, 1, cyc);
    chk("t5_nbeats", 64'(log_data.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk("t5_rdata", 64'(log_data[i]), 64'(32'hB0 + 32'(i)));
    chk("t5_rlast7", 64'(log_last[7]), 64'd1);

    // same-word read and write in one cycle
    @(posedge aclk); #1;
    s_awid_i = 5'd3; s_awaddr_i = BASE + 32'd4; s_awlen_i = 8'd0; s_awvalid_i = 1'b1;
    @(posedge aclk); #1;
    s_awvalid_i = 1'b0;
    s_wvalid_i = 1'b1; s_wdata_i = 32'hC1; s_wlast_i = 1'b1;
    s_arid_i = 5'd4; s_araddr_i = BASE + 32'd4; s_arlen_i = 8'd0; s_arvalid_i = 1'b1;
    @(posedge aclk); #1;
    s_wvalid_i = 1'b0; s_wlast_i = 1'b0; s_arvalid_i = 1'b0;
    chk("t6_rbw_old", 64'(s_rdata_o), 64'hB1);
    s_rready_i = 1'b1;
    @(posedge aclk); #1;
    s_rready_i = 1'b0; s_bready_i = 1'b1;
    @(posedge aclk); #1;
    s_bready_i = 1'b0;
    clr_log();
    do_read(5'd4, BASE + 32'd4, 0, 0, cyc);
    chk("t6_new", 64'(log_data[0]), 64'hC1);

    // reset in the middle of a read burst
    @(posedge aclk); #1;
    s_arid_i = 5'd2; s_araddr_i = BASE; s_arlen_i = 8'd7; s_arvalid_i = 1'b1;
    @(posedge aclk); #1;
    s_arvalid_i = 1'b0; s_rready_i = 1'b1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    chk("t7_rvalid", 64'(s_rvalid_o), 64'd0);
    s_rready_i = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("t7_arready", 64'(s_arready_o), 64'd1);
    clr_log();
    do_read(5'd1, BASE, 3, 0, cyc);
    chk("t7_persist", 64'(log_data[1]), 64'hC1);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      logic [31:0] addr;
      int len, nb;
      if ($urandom_range(0, 9) == 0)
        addr = BASE - 32'd64 + 32'($urandom_range(0, 3));
      else
        addr = BASE + 32'($urandom_range(0, DEPTH + 1) * 4) + 32'($urandom_range(0, 3));
      len = $urandom_range(0, 5);
      nb  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : len + 1;
      do_write(5'($urandom), addr, len, nb, 32'h0, 1'b1);
      do_read(5'($urandom), addr, $urandom_range(0, 5), 2, cyc);
    end

    repeat (3) @(posedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
